seq_detector: RTL

Parametrised Moore-style serial pattern detector. It watches a 1-bit stream qualified by an enable and raises a registered `match` flag when the last W sampled bits equal a compile-time pattern. It supports overlapping and non-overlapping detection and an optional saturating match counter. It sits beside the hand-coded control FSMs as the reusable, width-generic detector for serial control and handshake streams.

---
 rtl/seq_det_pkg.sv | 53 +++++
 rtl/seq_det_counter.sv | 30 +++
 rtl/seq_detector.sv | 75 +++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and elaboration-time helpers for the serial pattern detector.
// All functions are evaluated only on constants while building the next-state table.
package seq_det_pkg;

  localparam int unsigned MAX_W  = 16;
  localparam int unsigned SIDX_W = $clog2(MAX_W + 1);

  typedef logic [SIDX_W-1:0] state_idx_t;

  // Longest proper border: largest k < w whose k-bit prefix equals the k-bit suffix.
  function automatic state_idx_t border_len(logic [MAX_W-1:0] pattern, int unsigned w);
    state_idx_t res;
    logic       ok;
    res = '0;
    for (int unsigned k = 1; k < MAX_W; k++) begin
      if (k < w) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_W; i++) begin
          if (i < k) begin
            if (pattern[w-1-i] != pattern[k-1-i]) ok = 1'b0;
          end
        end
        if (ok) res = state_idx_t'(k);
      end
    end
    return res;
  endfunction

  // For s < w: longest suffix of (prefix_s, b) that is also a pattern prefix.
  function automatic state_idx_t next_state(logic [MAX_W-1:0] pattern, int unsigned w,
                                            int unsigned s, logic b);
    state_idx_t  res;
    logic        ok;
    logic        chr;
    int unsigned pos;
    res = '0;
    for (int unsigned k = 1; k <= MAX_W; k++) begin
      if (k <= s + 1) begin
        ok = 1'b1;
        for (int unsigned i = 0; i < MAX_W; i++) begin
          if (i < k) begin
            pos = s + 1 - k + i;
            chr = (pos == s) ? b : pattern[w-1-pos];
            if (pattern[w-1-i] != chr) ok = 1'b0;
          end
        end
        if (ok) res = state_idx_t'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seq_det_counter.sv
// Saturating hit counter; clear wins over a simultaneous increment.
module seq_det_counter #(
  parameter int unsigned CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] cnt
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {CW{1'b1}})) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/seq_detector.sv
// Moore serial pattern detector driven by an elaboration-time (W+1)x2 next-state table.
// Optional saturating hit counter and match_cnt port under SEQ_DETECTOR_COUNT_EN.
module seq_detector
  import seq_det_pkg::*;
#(
  parameter int unsigned     W       = 4,
  parameter logic [W-1:0]    PATTERN = 4'b1011,
  parameter bit              OVERLAP = 1'b1,
  parameter int unsigned     CW      = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   din,
  input  logic                   clr_cnt,
  output logic                   match,
  output logic [$clog2(W+1)-1:0] progress
`ifdef SEQ_DETECTOR_COUNT_EN
  ,
  output logic [CW-1:0]          match_cnt
`endif
);

  localparam int unsigned SW     = $clog2(W + 1);
  localparam state_idx_t  Border = border_len(MAX_W'(PATTERN), W);

  logic [SW-1:0] state_q, state_d;
  logic [SW-1:0] nxt_zero [W+1];
  logic [SW-1:0] nxt_one  [W+1];

  // From the full-match state, restart at the border (overlap) or from scratch.
  for (genvar s = 0; s <= W; s++) begin : g_tbl
    localparam int unsigned Src = (s == W) ? (OVERLAP ? int'(Border) : 0) : s;
    assign nxt_zero[s] = SW'(next_state(MAX_W'(PATTERN), W, Src, 1'b0));
    assign nxt_one[s]  = SW'(next_state(MAX_W'(PATTERN), W, Src, 1'b1));
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= '0;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (en) begin
      state_d = din ? nxt_one[state_q] : nxt_zero[state_q];
    end
  end

  always_comb begin
    match    = (state_q == SW'(W));
    progress = state_q;
  end

`ifdef SEQ_DETECTOR_COUNT_EN
  logic cnt_inc;
  assign cnt_inc = en && (state_d == SW'(W));

  seq_det_counter #(
    .CW (CW)
  ) u_cnt (
    .clk (clk),
    .rst (rst),
    .inc (cnt_inc),
    .clr (clr_cnt),
    .cnt (match_cnt)
  );
`else
  // Counter absent: clr_cnt and CW are intentionally unused.
  logic                 unused_clr_cnt;
  localparam int unsigned unused_cw = CW;
  assign unused_clr_cnt = clr_cnt;
`endif

endmodule
